tcam_action_stage: RTL and testbench

TCAM_ACTION_STAGE -- requirements
Module: tcam_action_stage

---
 rtl/tcam_action_stage.sv | 194 +++++++++++++++++++
 tb/tb_tcam_action_stage.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcam_action_stage.sv
// ---------------------------------------------------------------------------
// tcam_action_stage
//
// Takes TCAM lookup results (hit flag + matching rule index) together with the
// packet metadata. It resolves each result into an action word from a
// control-plane writable action table, or from default_action on a miss. It
// also keeps saturating per-rule hit counters plus one miss counter.
//
// Pipeline:
//   S1 registers {hit, index, meta} from the input handshake.
//   S2 registers the resolved action and drives the out_* ports.
//   Both stages use valid/ready handshakes. Backpressure from out_ready ripples
//   back so that the stage keeps full throughput with no bubbles.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              input handshake
//   in_hit, in_hit_index, in_meta  TCAM result and metadata
//   act_wr_en/addr/data            action table write port
//   default_action                 action used on a miss, sampled at resolve
//   cnt_rd_en/addr/clr             counter read (addr ENTRIES = miss counter)
//   cnt_rd_data                    registered counter read result
//   out_valid/out_ready            output handshake
//   out_hit, out_index, out_action, out_meta   resolved result
// ---------------------------------------------------------------------------
module tcam_action_stage #(
    parameter int ENTRIES = 16,
    parameter int ACT_W   = 32,
    parameter int META_W  = 16,
    parameter int CNT_W   = 32,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_hit,
    input  logic [IDX_W-1:0]  in_hit_index,
    input  logic [META_W-1:0] in_meta,
    input  logic              act_wr_en,
    input  logic [IDX_W-1:0]  act_wr_addr,
    input  logic [ACT_W-1:0]  act_wr_data,
    input  logic [ACT_W-1:0]  default_action,
    input  logic              cnt_rd_en,
    input  logic [IDX_W:0]    cnt_rd_addr,
    input  logic              cnt_rd_clr,
    output logic [CNT_W-1:0]  cnt_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_hit,
    output logic [IDX_W-1:0]  out_index,
    output logic [ACT_W-1:0]  out_action,
    output logic [META_W-1:0] out_meta
);

    localparam logic [IDX_W:0]   MISS_ADDR = (IDX_W + 1)'(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic              s1_valid;
    logic              s1_hit;
    logic [IDX_W-1:0]  s1_index;
    logic [META_W-1:0] s1_meta;
    logic              s2_valid;

    logic              s2_advance;
    logic              s1_advance;

    logic [ACT_W-1:0]  action_table [ENTRIES];
    logic [CNT_W-1:0]  counters [ENTRIES+1];

    logic [ACT_W-1:0]  resolved_action;
    logic [IDX_W:0]    inc_addr;
    logic [CNT_W-1:0]  rd_value;
    logic              cnt_clear;

    // Handshake chain. S2 frees up whenever it is empty or being drained.
    // S1 can then refill in the same cycle, so in_ready only drops when both
    // stages are full and downstream is stalled.
    assign s2_advance = !s2_valid || out_ready;
    assign s1_advance = s1_valid && s2_advance;
    assign in_ready   = !s1_valid || s2_advance;
    assign out_valid  = s2_valid;

    // Misses are counted in the extra counter that sits just past the rule counters.
    assign inc_addr  = s1_hit ? {1'b0, s1_index} : MISS_ADDR;
    assign cnt_clear = cnt_rd_en && cnt_rd_clr;

    // Action lookup for the item in S1. The table is read before any same-cycle
    // write lands, so a colliding write is seen only by later items.
    always_comb begin
        resolved_action = default_action;
        if (s1_hit) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (s1_index == IDX_W'(i)) begin
                    resolved_action = action_table[i];
                end
            end
        end
    end

    // Counter read mux. Addresses beyond the miss counter match nothing and read as zero.
    always_comb begin
        rd_value = '0;
        for (int i = 0; i <= ENTRIES; i++) begin
            if (cnt_rd_addr == (IDX_W + 1)'(i)) begin
                rd_value = counters[i];
            end
        end
    end

    // S1 register: reloads whenever it is allowed to accept.
    // It empties if nothing new arrives while its content moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s1_index <= '0;
            s1_meta  <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_hit   <= in_hit;
                s1_index <= in_hit_index;
                s1_meta  <= in_meta;
            end
        end
    end

    // S2 register: data fields change only on an actual S1->S2 transfer.
    // This keeps out_* stable while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            out_hit    <= 1'b0;
            out_index  <= '0;
            out_action <= '0;
            out_meta   <= '0;
        end else begin
            if (s2_advance) begin
                s2_valid <= s1_valid;
            end
            if (s1_advance) begin
                out_hit    <= s1_hit;
                out_index  <= s1_index;
                out_action <= resolved_action;
                out_meta   <= s1_meta;
            end
        end
    end

    // Control-plane action table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                action_table[i] <= '0;
            end
        end else if (act_wr_en) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (act_wr_addr == IDX_W'(i)) begin
                    action_table[i] <= act_wr_data;
                end
            end
        end
    end

    // Hit/miss counters. A clear takes priority over a plain increment.
    // When both land on the same counter in the same cycle, the surviving
    // increment leaves the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= ENTRIES; i++) begin
                counters[i] <= '0;
            end
        end else begin
            for (int i = 0; i <= ENTRIES; i++) begin
                if (cnt_clear && cnt_rd_addr == (IDX_W + 1)'(i)) begin
                    counters[i] <= (s1_advance && inc_addr == (IDX_W + 1)'(i)) ? CNT_W'(1) : '0;
                end else if (s1_advance && inc_addr == (IDX_W + 1)'(i) && counters[i] != CNT_MAX) begin
                    counters[i] <= counters[i] + CNT_W'(1);
                end
            end
        end
    end

    // Read data captures the pre-edge counter value and holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_rd_data <= '0;
        end else if (cnt_rd_en) begin
            cnt_rd_data <= rd_value;
        end
    end

endmodule

// File: tb/tb_tcam_action_stage.sv
// ---------------------------------------------------------------------------
// tb_tcam_action_stage
//
// Testbench for tcam_action_stage, built with CNT_W = 4 so that counter
// saturation is reachable quickly.
//
// The reference model treats the stage as an ordered list of in-flight items
// (at most two). The oldest item is resolved once it moves into the output
// slot. Actions and counters are kept as plain arrays and integers.
// ---------------------------------------------------------------------------
module tb_tcam_action_stage;

    localparam int ENTRIES = 16;
    localparam int ACT_W   = 32;
    localparam int META_W  = 16;
    localparam int CNT_W   = 4;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              in_hit;
    logic [IDX_W-1:0]  in_hit_index;
    logic [META_W-1:0] in_meta;
    logic              act_wr_en;
    logic [IDX_W-1:0]  act_wr_addr;
    logic [ACT_W-1:0]  act_wr_data;
    logic [ACT_W-1:0]  default_action;
    logic              cnt_rd_en;
    logic [IDX_W:0]    cnt_rd_addr;
    logic              cnt_rd_clr;
    logic [CNT_W-1:0]  cnt_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_hit;
    logic [IDX_W-1:0]  out_index;
    logic [ACT_W-1:0]  out_action;
    logic [META_W-1:0] out_meta;

    always #5 clk = ~clk;

    tcam_action_stage #(
        .ENTRIES(ENTRIES),
        .ACT_W  (ACT_W),
        .META_W (META_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_hit        (in_hit),
        .in_hit_index  (in_hit_index),
        .in_meta       (in_meta),
        .act_wr_en     (act_wr_en),
        .act_wr_addr   (act_wr_addr),
        .act_wr_data   (act_wr_data),
        .default_action(default_action),
        .cnt_rd_en     (cnt_rd_en),
        .cnt_rd_addr   (cnt_rd_addr),
        .cnt_rd_clr    (cnt_rd_clr),
        .cnt_rd_data   (cnt_rd_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_hit       (out_hit),
        .out_index     (out_index),
        .out_action    (out_action),
        .out_meta      (out_meta)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic              hit;
        logic [IDX_W-1:0]  idx;
        logic [META_W-1:0] meta;
        logic [ACT_W-1:0]  act;
        logic              promoted;
    } item_t;

    item_t            q[$];
    logic [ACT_W-1:0] m_act [ENTRIES];
    int               m_cnt [ENTRIES+1];
    logic [CNT_W-1:0] m_rd;
    logic             exp_in_ready;
    logic             obs_in_ready;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < ENTRIES; i++) m_act[i] = '0;
        for (int i = 0; i <= ENTRIES; i++) m_cnt[i] = 0;
        m_rd = '0;
    endtask

    // Advance the model by one edge using the inputs currently driven,
    // then let the DUT take the same edge.
    task automatic tick();
        bit    has2;
        bit    promote;
        int    pidx;
        int    inc_sel;
        int    rd_a;
        item_t it;
        @(negedge clk);
        obs_in_ready = in_ready;
        exp_in_ready = (q.size() < 2) || out_ready;
        has2    = (q.size() > 0) && q[0].promoted;
        pidx    = has2 ? 1 : 0;
        promote = (q.size() > pidx) && (!has2 || out_ready);
        inc_sel = -1;
        if (promote) begin
            q[pidx].act      = q[pidx].hit ? m_act[q[pidx].idx] : default_action;
            q[pidx].promoted = 1'b1;
            inc_sel          = q[pidx].hit ? int'(q[pidx].idx) : ENTRIES;
        end
        rd_a = int'(cnt_rd_addr);
        if (cnt_rd_en) begin
            if (rd_a <= ENTRIES) m_rd = CNT_W'(m_cnt[rd_a]);
            else m_rd = '0;
        end
        if (inc_sel >= 0 && m_cnt[inc_sel] < CNT_MAX) m_cnt[inc_sel]++;
        if (cnt_rd_en && cnt_rd_clr && rd_a <= ENTRIES) m_cnt[rd_a] = (inc_sel == rd_a) ? 1 : 0;
        if (act_wr_en) m_act[act_wr_addr] = act_wr_data;
        if (has2 && out_ready) void'(q.pop_front());
        if (in_valid && exp_in_ready) begin
            it.hit = in_hit; it.idx = in_hit_index; it.meta = in_meta;
            it.act = '0; it.promoted = 1'b0;
            q.push_back(it);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_hit = 0; in_hit_index = '0; in_meta = '0;
        act_wr_en = 0; act_wr_addr = '0; act_wr_data = '0;
        cnt_rd_en = 0; cnt_rd_addr = '0; cnt_rd_clr = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 1; default_action = '0;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
        tests_run++;
        if ({out_hit, out_index, out_action, out_meta, cnt_rd_data} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got hit=%0b idx=%0h act=%0h meta=%0h rd=%0h expected all 0",
                     out_hit, out_index, out_action, out_meta, cnt_rd_data);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_hit_action();
        out_ready = 1;
        act_wr_en = 1; act_wr_addr = 4'd3; act_wr_data = 32'hA5A5_0003;
        tick();
        act_wr_en = 0;
        in_valid = 1; in_hit = 1; in_hit_index = 4'd3; in_meta = 16'h1234;
        tick();
        in_valid = 0;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL hit_latency_early: got out_valid %0b expected 0", out_valid); end
        tick();
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL hit_latency: got out_valid %0b expected 1", out_valid); end
        tests_run++;
        if ({out_hit, out_action, out_meta} !== {1'b1, 32'hA5A5_0003, 16'h1234}) begin
            tests_failed++;
            $display("[TB] FAIL hit_result: got hit=%0b act=%0h meta=%0h expected hit=1 act=a5a50003 meta=1234",
                     out_hit, out_action, out_meta);
        end
        tick();
    endtask

    task automatic test_miss_default();
        out_ready = 1; default_action = 32'hDEAD_0000;
        in_valid = 1; in_hit = 0; in_hit_index = 4'd7; in_meta = 16'h55AA;
        tick();
        in_valid = 0;
        tick();
        tests_run++;
        if ({out_valid, out_hit, out_index, out_action, out_meta} !== {1'b1, 1'b0, 4'd7, 32'hDEAD_0000, 16'h55AA}) begin
            tests_failed++;
            $display("[TB] FAIL miss_result: got v=%0b hit=%0b idx=%0h act=%0h meta=%0h expected v=1 hit=0 idx=7 act=dead0000 meta=55aa",
                     out_valid, out_hit, out_index, out_action, out_meta);
        end
        cnt_rd_en = 1; cnt_rd_addr = 5'd16; cnt_rd_clr = 0;
        tick();
        cnt_rd_en = 0;
        tests_run++;
        if (cnt_rd_data !== 4'd1) begin tests_failed++; $display("[TB] FAIL miss_counter: got %0d expected 1", cnt_rd_data); end
    endtask

    task automatic test_back_to_back();
        logic [META_W-1:0] got[$];
        int sent = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready    = (cyc >= 3);
            in_valid     = (sent < 4);
            in_hit       = 1;
            in_hit_index = IDX_W'(sent);
            in_meta      = 16'h0100 + 16'(sent);
            #1;
            if (cyc == 2) begin
                tests_run++;
                if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_backpressure: got in_ready %0b expected 0", in_ready); end
            end
            if (cyc == 2 || cyc == 3) begin
                tests_run++;
                if ({out_valid, out_meta} !== {1'b1, 16'h0100}) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_hold: got v=%0b meta=%0h expected v=1 meta=100", out_valid, out_meta);
                end
            end
            if (out_valid && out_ready) got.push_back(out_meta);
            if (in_valid && in_ready) sent++;
            tick();
        end
        idle_inputs();
        tests_run++;
        if (got.size() != 4) begin tests_failed++; $display("[TB] FAIL b2b_count: got %0d items expected 4", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            tests_run++;
            if (got[i] !== 16'h0100 + 16'(i)) begin
                tests_failed++;
                $display("[TB] FAIL b2b_order: item %0d got meta %0h expected %0h", i, got[i], 16'h0100 + 16'(i));
            end
        end
    endtask

    task automatic test_saturation();
        int sent = 0;
        out_ready = 1;
        for (int cyc = 0; cyc < 40 && sent < 20; cyc++) begin
            in_valid = 1; in_hit = 1; in_hit_index = 4'd5; in_meta = 16'(cyc);
            #1;
            if (in_ready) sent++;
            tick();
        end
        in_valid = 0;
        repeat (3) tick();
        cnt_rd_en = 1; cnt_rd_addr = 5'd5; cnt_rd_clr = 0;
        tick();
        tests_run++;
        if (cnt_rd_data !== 4'd15) begin tests_failed++; $display("[TB] FAIL sat_read: got %0d expected 15", cnt_rd_data); end
        cnt_rd_clr = 1;
        tick();
        tests_run++;
        if (cnt_rd_data !== 4'd15) begin tests_failed++; $display("[TB] FAIL sat_clear_read: got %0d expected 15", cnt_rd_data); end
        cnt_rd_clr = 0;
        tick();
        tests_run++;
        if (cnt_rd_data !== 4'd0) begin tests_failed++; $display("[TB] FAIL sat_after_clear: got %0d expected 0", cnt_rd_data); end
        cnt_rd_en = 0;
        cnt_rd_addr = 5'd20;
        cnt_rd_en = 1;
        tick();
        cnt_rd_en = 0;
        tests_run++;
        if (cnt_rd_data !== 4'd0) begin tests_failed++; $display("[TB] FAIL read_out_of_range: got %0d expected 0", cnt_rd_data); end
    endtask

    task automatic test_clear_collision();
        out_ready = 1;
        cnt_rd_en = 1; cnt_rd_addr = 5'd2; cnt_rd_clr = 1;
        tick();
        cnt_rd_en = 0; cnt_rd_clr = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_hit = 1; in_hit_index = 4'd2; in_meta = 16'h0200 + 16'(i);
            tick();
        end
        in_valid = 0;
        repeat (3) tick();
        in_valid = 1; in_hit = 1; in_hit_index = 4'd2; in_meta = 16'h02FF;
        tick();
        in_valid = 0;
        cnt_rd_en = 1; cnt_rd_addr = 5'd2; cnt_rd_clr = 1;
        tick();
        tests_run++;
        if (cnt_rd_data !== 4'd3) begin tests_failed++; $display("[TB] FAIL collide_read: got %0d expected 3", cnt_rd_data); end
        cnt_rd_clr = 0;
        tick();
        cnt_rd_en = 0;
        tests_run++;
        if (cnt_rd_data !== 4'd1) begin tests_failed++; $display("[TB] FAIL collide_after: got %0d expected 1", cnt_rd_data); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_hit = 1; in_hit_index = IDX_W'(i); in_meta = 16'h0300 + 16'(i);
            tick();
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if ({out_valid, in_ready, out_meta} !== {1'b0, 1'b1, 16'h0000}) begin
            tests_failed++;
            $display("[TB] FAIL midreset_immediate: got v=%0b rdy=%0b meta=%0h expected v=0 rdy=1 meta=0", out_valid, in_ready, out_meta);
        end
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_stale: cycle %0d got out_valid %0b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_random();
        bit exp_ov;
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid       = ($urandom_range(0, 3) != 0);
            in_hit         = ($urandom_range(0, 3) != 0);
            in_hit_index   = IDX_W'($urandom_range(0, ENTRIES - 1));
            in_meta        = META_W'($urandom);
            out_ready      = ($urandom_range(0, 2) != 0);
            act_wr_en      = ($urandom_range(0, 3) == 0);
            act_wr_addr    = IDX_W'($urandom_range(0, ENTRIES - 1));
            act_wr_data    = $urandom;
            default_action = $urandom;
            cnt_rd_en      = ($urandom_range(0, 1) == 0);
            cnt_rd_addr    = (IDX_W + 1)'($urandom_range(0, 2 * ENTRIES - 1));
            cnt_rd_clr     = ($urandom_range(0, 3) == 0);
            tick();
            tests_run++;
            if (obs_in_ready !== exp_in_ready) begin
                tests_failed++;
                $display("[TB] FAIL rand_in_ready: cycle %0d got %0b expected %0b", cyc, obs_in_ready, exp_in_ready);
            end
            exp_ov = (q.size() > 0) && q[0].promoted;
            tests_run++;
            if (out_valid !== exp_ov) begin
                tests_failed++;
                $display("[TB] FAIL rand_out_valid: cycle %0d got %0b expected %0b", cyc, out_valid, exp_ov);
            end
            if (exp_ov) begin
                tests_run++;
                if ({out_hit, out_index, out_action, out_meta} !== {q[0].hit, q[0].idx, q[0].act, q[0].meta}) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_out_data: cycle %0d got hit=%0b idx=%0h act=%0h meta=%0h expected hit=%0b idx=%0h act=%0h meta=%0h",
                             cyc, out_hit, out_index, out_action, out_meta, q[0].hit, q[0].idx, q[0].act, q[0].meta);
                end
            end
            tests_run++;
            if (cnt_rd_data !== m_rd) begin
                tests_failed++;
                $display("[TB] FAIL rand_cnt_rd: cycle %0d got %0d expected %0d", cyc, cnt_rd_data, m_rd);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_hit_action();
        test_miss_default();
        test_back_to_back();
        test_saturation();
        test_clear_collision();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
